// File: rtl/mem_access_pkg.sv
// Shared FSM state encoding, error codes and op classification for the memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS     = 2'b00,
        OP_MEM      = 2'b01,
        OP_MISALIGN = 2'b10,
        OP_ILLEGAL  = 2'b11
    } op_kind_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Both-enable is illegal regardless of alignment; alignment only matters for real memory ops.
    function automatic op_kind_e classify_op(input logic rd, input logic wr, input logic [1:0] lsb);
        if (rd && wr)        return OP_ILLEGAL;
        if (!rd && !wr)      return OP_PASS;
        if (lsb != 2'b00)    return OP_MISALIGN;
        return OP_MEM;
    endfunction

endpackage

// File: rtl/mau_timeout_ctr.sv
// Counts unacknowledged request cycles; expired flags the TIMEOUT-th such cycle (combinational).
// No backpressure: clear has priority over enable, count saturates at expiry.
module mau_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: pass-through (1 cycle to wb_valid) or single-beat load/store with ack timeout.
// One op in flight; in_ready only in IDLE, writeback held until wb_ready.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [DATA_W-1:0] Read_data2,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [4:0]        Rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_regwrite,
    output logic [1:0]        err
);
    state_e            state_q, state_d;
    op_kind_e          kind;
    logic              accept;
    logic              expired;
    logic              ctr_en;

    logic              mem_we_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              wb_regwrite_q;
    logic [1:0]        err_q;

    // Gated by rst_n so the unit advertises not-ready for the whole reset window.
    assign in_ready = (state_q == ST_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign kind     = classify_op(MemRead, MemWrite, ALU_Result[1:0]);
    assign ctr_en   = (state_q == ST_REQ) && !mem_ack;

    mau_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (ctr_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (kind == OP_MEM) ? ST_REQ : ST_RESP;
            ST_REQ:  if (mem_ack || expired) state_d = ST_RESP;
            ST_RESP: if (wb_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            err_q         <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wb_rd_q <= Rd;
                        case (kind)
                            OP_PASS: begin
                                wb_data_q     <= ALU_Result;
                                wb_regwrite_q <= RegWrite;
                                err_q         <= ERR_NONE;
                            end
                            OP_MEM: begin
                                mem_addr_q    <= ALU_Result;
                                mem_we_q      <= MemWrite;
                                mem_wdata_q   <= Read_data2;
                                wb_data_q     <= '0;
                                wb_regwrite_q <= RegWrite && MemRead;
                                err_q         <= ERR_NONE;
                            end
                            OP_MISALIGN: begin
                                wb_data_q     <= '0;
                                wb_regwrite_q <= 1'b0;
                                err_q         <= ERR_MISALIGN;
                            end
                            default: begin
                                wb_data_q     <= '0;
                                wb_regwrite_q <= 1'b0;
                                err_q         <= ERR_ILLEGAL;
                            end
                        endcase
                    end
                end
                ST_REQ: begin
                    // Ack beats a same-cycle expiry.
                    if (mem_ack) begin
                        wb_data_q <= mem_we_q ? '0 : mem_rdata;
                    end else if (expired) begin
                        wb_regwrite_q <= 1'b0;
                        err_q         <= ERR_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    if (wb_ready) err_q <= ERR_NONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_req     = (state_q == ST_REQ);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = (state_q == ST_RESP);
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_regwrite_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level reference model.
module tb_mem_access_unit;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] ALU_Result;
    logic [DW-1:0] Read_data2;
    logic          MemRead;
    logic          MemWrite;
    logic          RegWrite;
    logic [4:0]    Rd;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rd;
    logic          wb_regwrite;
    logic [1:0]    err;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_Result  (ALU_Result),
        .Read_data2  (Read_data2),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .Rd          (Rd),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: rd/wr/rw control, ack on the L-th request cycle (L>TO means never), stall wb_ready.
    task automatic do_op(input logic rd, input logic wr, input logic rw, input logic [4:0] rdn,
                         input logic [DW-1:0] alu, input logic [DW-1:0] d2, input logic [DW-1:0] rdat,
                         input int L, input int stall);
        bit            is_mem;
        bit            timed_out;
        int            exp_reqs;
        int            reqs;
        int            waitc;
        logic [1:0]    exp_err;
        logic          exp_rw;
        logic [DW-1:0] exp_data;
        bit            chk_data;

        // Reference model: derive the transaction outcome directly from the rules.
        is_mem    = (rd != wr) && (alu[1:0] == 2'b00);
        timed_out = is_mem && (L > TO);
        exp_reqs  = !is_mem ? 0 : (timed_out ? TO : L);
        chk_data  = 1'b1;
        if (rd && wr) begin
            exp_err = 2'b11; exp_rw = 1'b0; exp_data = '0; chk_data = 1'b0;
        end else if (!rd && !wr) begin
            exp_err = 2'b00; exp_rw = rw; exp_data = alu;
        end else if (!is_mem) begin
            exp_err = 2'b01; exp_rw = 1'b0; exp_data = '0; chk_data = 1'b0;
        end else if (timed_out) begin
            exp_err = 2'b10; exp_rw = 1'b0; exp_data = '0; chk_data = 1'b0;
        end else begin
            exp_err = 2'b00; exp_rw = rd ? rw : 1'b0; exp_data = rd ? rdat : '0;
        end

        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1; waitc++;
        end
        check_eq("in_ready_idle", in_ready, 1);

        MemRead = rd; MemWrite = wr; RegWrite = rw; Rd = rdn;
        ALU_Result = alu; Read_data2 = d2; in_valid = 1'b1;
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0; mem_ack = 1'b0;
        ALU_Result = $urandom; Read_data2 = $urandom; Rd = 5'($urandom);

        if (!is_mem) begin
            check_eq("no_mem_req", mem_req, 0);
            check_eq("wb_valid_lat1", wb_valid, 1);
        end
        reqs = 0;
        while (mem_req && reqs < 40) begin
            reqs++;
            check_eq("req_addr", mem_addr, alu);
            check_eq("req_we", mem_we, wr);
            check_eq("req_wdata", mem_wdata, d2);
            check_eq("req_no_wbv", wb_valid, 0);
            mem_ack   = (reqs == L);
            mem_rdata = (reqs == L) ? rdat : DW'($urandom);
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        check_eq("req_cycles", reqs, exp_reqs);

        for (int s = 0; s <= stall; s++) begin
            check_eq("wb_valid", wb_valid, 1);
            check_eq("in_ready_busy", in_ready, 0);
            check_eq("wb_rd", wb_rd, rdn);
            check_eq("wb_regwrite", wb_regwrite, exp_rw);
            check_eq("err", err, exp_err);
            if (chk_data) check_eq("wb_data", wb_data, exp_data);
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            wb_ready  = (s == stall);
            @(posedge clk); #1;
        end
        wb_ready = 1'b0; mem_ack = 1'b0;
        check_eq("wb_valid_drop", wb_valid, 0);
        check_eq("err_clear", err, 0);
        check_eq("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic       rd, wr;
        int         k;
        logic [DW-1:0] a;

        rst_n = 1'b0; in_valid = 1'b0; ALU_Result = '0; Read_data2 = '0;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; Rd = '0;
        mem_rdata = '0; mem_ack = 1'b0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_rd", wb_rd, 0);
        check_eq("rst_wb_regwrite", wb_regwrite, 0);
        check_eq("rst_err", err, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed scenarios
        do_op(0, 0, 1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1, 0);
        do_op(1, 0, 1, 5'd7, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0);
        do_op(0, 1, 1, 5'd3, 32'h0000_0104, 32'h55, 32'h0, 2, 4);
        do_op(1, 0, 1, 5'd9, 32'h0000_0102, 32'h0, 32'h0, 1, 0);
        do_op(1, 1, 1, 5'd9, 32'h0000_0100, 32'h0, 32'h0, 1, 0);
        do_op(1, 0, 1, 5'd4, 32'h0000_0200, 32'h0, 32'h1111_2222, 99, 1);
        do_op(1, 0, 1, 5'd4, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, TO, 0);

        // Reset in REQ with an ack arriving alongside and after reset
        MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; Rd = 5'd2;
        ALU_Result = 32'h0000_0300; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rq_mem_req_before", mem_req, 1);
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        check_eq("rq_async_mem_req", mem_req, 0);
        check_eq("rq_async_wb_valid", wb_valid, 0);
        check_eq("rq_async_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_eq("rq_after_mem_req", mem_req, 0);
        check_eq("rq_after_wb_valid", wb_valid, 0);
        check_eq("rq_after_err", err, 0);
        check_eq("rq_after_in_ready", in_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 4);
            a = $urandom;
            case (k)
                0: begin rd = 0; wr = 0; end
                1: begin rd = 1; wr = 0; a[1:0] = 2'b00; end
                2: begin rd = 0; wr = 1; a[1:0] = 2'b00; end
                3: begin rd = 1'($urandom_range(0, 1)); wr = !rd; a[1:0] = 2'($urandom_range(1, 3)); end
                default: begin rd = 1; wr = 1; end
            endcase
            do_op(rd, wr, 1'($urandom_range(0, 1)), 5'($urandom), a, $urandom, $urandom,
                  $urandom_range(1, TO + 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
